pc_redirect_sequencer: RTL and testbench
========================================

// Module: pc_redirect_sequencer
// PURPOSE
//   Next-PC controller for the fetch stage. Arbitrates redirect requests (exception, eret, jr, j, branch)
//   and drives the mode/operand pair of the program counter (mode 00 seq, 01 rel, 10 abs26, 11 full addr).
//   If a redirect arrives while fetch is stalled, it is captured and replayed when the stall drops.
//   Emits a write enable, a one-cycle flush pulse and a saturating redirect counter for performance stats.
// PARAMETERS
//   EXC_VECTOR   32'h00004180   full exception-entry address (mode 11)
//   CNT_W        16             width of redirect_count
// PORTS
//   clock           in   1      single clock, rising edge
//   reset           in   1      synchronous, active-high
//   stall           in   1      fetch stall; PC must not advance
//   exc_req         in   1      exception entry request
//   eret_req        in   1      return-from-exception request
//   epc             in   32     eret target, full address
//   jr_req          in   1      jump-register request
//   jr_target       in   32     jr target, full address
//   jump_req        in   1      j/jal request
//   jump_target     in   26     instr_index field
//   branch_req      in   1      taken-branch request
//   branch_offset   in   32     sign-extended word offset, unshifted
//   pc_write_en     out  1      PC may update at this edge
//   pc_jump_mode    out  2      mode to PC
//   pc_jump_input   out  32     operand to PC
//   flush           out  1      squash younger fetched instrs this cycle
//   redirect_pending out 1      captured redirect waiting on stall
//   redirect_count  out  CNT_W  applied redirects, saturating
// BEHAVIOUR
//   - Priority, highest first: exc > eret > jr > jump > branch. Only the winner is acted on.
//   - Encoding: exc -> 11/EXC_VECTOR; eret -> 11/epc; jr -> 11/jr_target; jump -> 10/{6'b0,jump_target};
//     branch -> 01/branch_offset; none -> 00/32'h0.
//   - Outputs are combinational from state + inputs (zero latency), so the PC samples them at the same edge.
//   - FSM states: RUN, HOLD. Pending reg {mode,operand,prio} is updated only at clock edges.
//   - RUN, !stall: pc_write_en=1; mode/input = winner encoding; flush=1 iff a request is present; stay RUN.
//   - RUN, stall: pc_write_en=0, flush=0, mode 00. If any request: latch winner, go HOLD. Else stay RUN.
//   - HOLD, stall: pc_write_en=0, flush=0. A new request of strictly higher priority than the latched one
//     overwrites the latch. Equal or lower priority requests are dropped (wrong-path). Stay HOLD.
//   - HOLD, !stall: pc_write_en=1; drive latched mode/operand; flush=1; go RUN. Live requests this cycle are
//     ignored (they are wrong-path relative to the redirect), except exc. exc overrides the latch and is applied.
//   - redirect_pending = (state==HOLD).
//   - redirect_count increments by 1 on each cycle with pc_write_en & flush. It holds at all-ones.
//   - Reset (any state, mid-hold included): state RUN, latch cleared, redirect_count=0. While reset=1 the
//     outputs are pc_write_en=0, flush=0, mode 00, input 0, pending 0. The PC applies its own INIT_PC.
// TESTING
//   1 reset 2 cycles, then idle, no stall -> pc_write_en=1, mode 00, flush=0, redirect_count=0.
//   2 jump_req target 26'h0000C10, branch_req same cycle -> mode 10, input 32'h00000C10, flush=1, count=1.
//   3 stall=1 + branch_req offset 32'hFFFFFFFC; 3 stall cycles; then stall=0 -> pending=1 during hold,
//     write_en=0. On release: mode 01, input FFFFFFFC, flush=1, pending=0 the next cycle.
//   4 in HOLD with branch latched, jr_req target 32'h00003400 while stalled, then release -> mode 11,
//     input 00003400. A later jump_req during hold is dropped.
//   5 exc_req + eret_req + jr_req together, no stall -> mode 11, input EXC_VECTOR 32'h00004180, flush=1.
//   6 reset asserted while in HOLD -> next cycle RUN, pending=0, count=0. Saturation check with CNT_W=2:
//     5 redirects -> count stays 2'b11.

Source files
------------

// File: rtl/pc_redirect_sequencer.sv
// Next-PC controller: picks the highest-priority redirect, holds it across fetch
// stalls, and drives the PC mode/operand pair plus flush and redirect statistics.
module pc_redirect_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h00004180,
  parameter int          CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  input  logic             jr_req,
  input  logic [31:0]      jr_target,
  input  logic             jump_req,
  input  logic [25:0]      jump_target,
  input  logic             branch_req,
  input  logic [31:0]      branch_offset,
  output logic             pc_write_en,
  output logic [1:0]       pc_jump_mode,
  output logic [31:0]      pc_jump_input,
  output logic             flush,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic {RUN, HOLD} state_t;

  // Priority ranks: larger wins, 0 means no request.
  localparam logic [2:0] PRI_NONE = 3'd0;
  localparam logic [2:0] PRI_BR   = 3'd1;
  localparam logic [2:0] PRI_J    = 3'd2;
  localparam logic [2:0] PRI_JR   = 3'd3;
  localparam logic [2:0] PRI_ERET = 3'd4;
  localparam logic [2:0] PRI_EXC  = 3'd5;

  state_t           state_reg, state_next;
  logic [1:0]       lat_mode_reg, lat_mode_next;
  logic [31:0]      lat_op_reg, lat_op_next;
  logic [2:0]       lat_pri_reg, lat_pri_next;
  logic [CNT_W-1:0] count_reg;

  logic [1:0]  win_mode;
  logic [31:0] win_op;
  logic [2:0]  win_pri;

  always_comb begin
    win_mode = 2'b00;
    win_op   = 32'h0;
    win_pri  = PRI_NONE;
    if (exc_req) begin
      win_mode = 2'b11;
      win_op   = EXC_VECTOR;
      win_pri  = PRI_EXC;
    end else if (eret_req) begin
      win_mode = 2'b11;
      win_op   = epc;
      win_pri  = PRI_ERET;
    end else if (jr_req) begin
      win_mode = 2'b11;
      win_op   = jr_target;
      win_pri  = PRI_JR;
    end else if (jump_req) begin
      win_mode = 2'b10;
      win_op   = {6'b0, jump_target};
      win_pri  = PRI_J;
    end else if (branch_req) begin
      win_mode = 2'b01;
      win_op   = branch_offset;
      win_pri  = PRI_BR;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lat_mode_next = lat_mode_reg;
    lat_op_next   = lat_op_reg;
    lat_pri_next  = lat_pri_reg;
    pc_write_en   = 1'b0;
    pc_jump_mode  = 2'b00;
    pc_jump_input = 32'h0;
    flush         = 1'b0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          if (!stall) begin
            pc_write_en   = 1'b1;
            pc_jump_mode  = win_mode;
            pc_jump_input = win_op;
            flush         = (win_pri != PRI_NONE);
          end else if (win_pri != PRI_NONE) begin
            lat_mode_next = win_mode;
            lat_op_next   = win_op;
            lat_pri_next  = win_pri;
            state_next    = HOLD;
          end
        end
        HOLD: begin
          if (stall) begin
            // Equal or lower priority arrivals are on the wrong path and dropped.
            if (win_pri > lat_pri_reg) begin
              lat_mode_next = win_mode;
              lat_op_next   = win_op;
              lat_pri_next  = win_pri;
            end
          end else begin
            pc_write_en   = 1'b1;
            flush         = 1'b1;
            state_next    = RUN;
            lat_pri_next  = PRI_NONE;
            // Only an exception can pre-empt the replayed redirect.
            if (exc_req) begin
              pc_jump_mode  = 2'b11;
              pc_jump_input = EXC_VECTOR;
            end else begin
              pc_jump_mode  = lat_mode_reg;
              pc_jump_input = lat_op_reg;
            end
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= RUN;
      lat_mode_reg <= 2'b00;
      lat_op_reg   <= 32'h0;
      lat_pri_reg  <= PRI_NONE;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      lat_mode_reg <= lat_mode_next;
      lat_op_reg   <= lat_op_next;
      lat_pri_reg  <= lat_pri_next;
      if (pc_write_en && flush && (count_reg != {CNT_W{1'b1}}))
        count_reg <= count_reg + 1'b1;
    end
  end

  assign redirect_pending = !reset && (state_reg == HOLD);
  assign redirect_count   = count_reg;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Scoreboard bench: a request-level model predicts every cycle's outputs for a
// 16-bit-counter and a 2-bit-counter instance; a negedge monitor compares them.
module tb_pc_redirect_sequencer;

  localparam logic [31:0] EXC = 32'h00004180;

  logic        clock = 1'b0;
  logic        reset, stall, exc_req, eret_req, jr_req, jump_req, branch_req;
  logic [31:0] epc, jr_target, branch_offset;
  logic [25:0] jump_target;

  logic        we_a, fl_a, pend_a, we_b, fl_b, pend_b;
  logic [1:0]  mode_a, mode_b, cnt_b;
  logic [31:0] op_a, op_b;
  logic [15:0] cnt_a;

  always #5 clock = ~clock;

  pc_redirect_sequencer #(.EXC_VECTOR(EXC), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .jr_req(jr_req), .jr_target(jr_target), .jump_req(jump_req),
    .jump_target(jump_target), .branch_req(branch_req), .branch_offset(branch_offset),
    .pc_write_en(we_a), .pc_jump_mode(mode_a), .pc_jump_input(op_a), .flush(fl_a),
    .redirect_pending(pend_a), .redirect_count(cnt_a));

  pc_redirect_sequencer #(.EXC_VECTOR(EXC), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .jr_req(jr_req), .jr_target(jr_target), .jump_req(jump_req),
    .jump_target(jump_target), .branch_req(branch_req), .branch_offset(branch_offset),
    .pc_write_en(we_b), .pc_jump_mode(mode_b), .pc_jump_input(op_b), .flush(fl_b),
    .redirect_pending(pend_b), .redirect_count(cnt_b));

  typedef struct {
    int          cyc;
    logic        we;
    logic [1:0]  mode;
    logic [31:0] op;
    logic        fl;
    logic        pend;
    int          c16;
    int          c2;
    bit          cknown;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Reference model state: pending redirect as a plain record, counters as ints.
  bit          m_hold = 0;
  logic [1:0]  m_mode = 2'b00;
  logic [31:0] m_op = 32'h0;
  int          m_rank = 0;
  int          m_c16 = 0;
  int          m_c2 = 0;
  bit          m_known = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
    end
  endtask

  // Applies the current inputs to the model, queues the expected outputs, advances a cycle.
  task automatic step();
    exp_t        e;
    bit          reqs[5];
    logic [1:0]  modes[5];
    logic [31:0] ops[5];
    int          w_rank;
    logic [1:0]  w_mode;
    logic [31:0] w_op;
    reqs  = '{exc_req, eret_req, jr_req, jump_req, branch_req};
    modes = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01};
    ops   = '{EXC, epc, jr_target, {6'b0, jump_target}, branch_offset};
    w_rank = 0; w_mode = 2'b00; w_op = 32'h0;
    for (int i = 4; i >= 0; i--)
      if (reqs[i]) begin w_rank = 5 - i; w_mode = modes[i]; w_op = ops[i]; end
    e.cyc = cyc; e.we = 0; e.mode = 2'b00; e.op = 32'h0; e.fl = 0;
    e.pend = m_hold && !reset; e.c16 = m_c16; e.c2 = m_c2; e.cknown = m_known;
    if (reset) begin
      m_hold = 0; m_rank = 0; m_c16 = 0; m_c2 = 0; m_known = 1;
    end else if (!m_hold) begin
      if (!stall) begin
        e.we = 1; e.mode = w_mode; e.op = w_op; e.fl = (w_rank != 0);
      end else if (w_rank != 0) begin
        m_hold = 1; m_mode = w_mode; m_op = w_op; m_rank = w_rank;
      end
    end else if (stall) begin
      if (w_rank > m_rank) begin m_mode = w_mode; m_op = w_op; m_rank = w_rank; end
    end else begin
      e.we = 1; e.fl = 1;
      e.mode = exc_req ? 2'b11 : m_mode;
      e.op   = exc_req ? EXC : m_op;
      m_hold = 0; m_rank = 0;
    end
    if (!reset && e.we && e.fl) begin
      if (m_c16 < 65535) m_c16++;
      if (m_c2 < 3) m_c2++;
    end
    sb.push_back(e);
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic set_in(input bit r, input bit s, input bit ex, input bit er, input bit j_r,
                        input bit jp, input bit br);
    reset = r; stall = s; exc_req = ex; eret_req = er; jr_req = j_r; jump_req = jp; branch_req = br;
  endtask

  // Monitor: pops one expectation per cycle and compares both instances.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("write_en", e.cyc, {31'b0, we_a}, {31'b0, e.we});
        chk("mode", e.cyc, {30'b0, mode_a}, {30'b0, e.mode});
        chk("input", e.cyc, op_a, e.op);
        chk("flush", e.cyc, {31'b0, fl_a}, {31'b0, e.fl});
        chk("pending", e.cyc, {31'b0, pend_a}, {31'b0, e.pend});
        chk("b_write_en", e.cyc, {31'b0, we_b}, {31'b0, e.we});
        chk("b_flush", e.cyc, {31'b0, fl_b}, {31'b0, e.fl});
        chk("b_pending", e.cyc, {31'b0, pend_b}, {31'b0, e.pend});
        if (e.cknown) begin
          chk("count16", e.cyc, {16'b0, cnt_a}, e.c16);
          chk("count2", e.cyc, {30'b0, cnt_b}, e.c2);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    epc = 32'h00001000; jr_target = 32'h00003400; jump_target = 26'h0000C10;
    branch_offset = 32'hFFFFFFFC;
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    // 1: reset two cycles, then idle
    step(); step();
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    // 2: jump beats branch
    set_in(0, 0, 0, 0, 0, 1, 1); step();
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    // 3: branch captured under stall, replayed on release
    set_in(0, 1, 0, 0, 0, 0, 1); step();
    set_in(0, 1, 0, 0, 0, 0, 0); step(); step();
    set_in(0, 0, 0, 0, 0, 0, 0); step(); step();
    // 4: jr overrides latched branch, later jump dropped
    set_in(0, 1, 0, 0, 0, 0, 1); step();
    set_in(0, 1, 0, 0, 1, 0, 0); step();
    set_in(0, 1, 0, 0, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0); step(); step();
    // 5: exc wins over eret and jr
    set_in(0, 0, 1, 1, 1, 0, 0); step();
    // exc on release overrides a latched jr; live jump on release ignored
    set_in(0, 1, 0, 0, 1, 0, 0); step();
    set_in(0, 0, 1, 0, 0, 0, 0); step();
    set_in(0, 1, 0, 0, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 1, 0); step();
    // 6: reset while holding
    set_in(0, 1, 0, 1, 0, 0, 0); step();
    set_in(1, 1, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    // saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) begin set_in(0, 0, 0, 0, 0, 0, 1); step(); end
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 45);
      exc_req = ($urandom_range(0, 99) < 6);
      eret_req = ($urandom_range(0, 99) < 10);
      jr_req = ($urandom_range(0, 99) < 15);
      jump_req = ($urandom_range(0, 99) < 15);
      branch_req = ($urandom_range(0, 99) < 20);
      epc = $urandom; jr_target = $urandom; branch_offset = $urandom;
      jump_target = 26'($urandom);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin @(posedge clock); wait_cycles++; end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
